// File: rtl/capture_pkg.sv
// Shared types and constants for the sample capture block: FSM states,
// the three selectable acquisition depths and the dump header sync byte.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TRIG,
        CAPTURE,
        DUMP,
        DONE
    } cap_state_t;

    localparam int DEPTH_L1 = 1024;
    localparam int DEPTH_L2 = 5120;
    localparam int DEPTH_L3 = 10240;

    localparam logic [7:0] HDR_SYNC = 8'hA5;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer: one write port and one read port with
// a single cycle of registered read latency, shaped to infer block RAM.
module sample_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array or read register so the tools can map it to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sample_capture.sv
// Captures 1K/5K/10K ADC samples into a RAM buffer, then streams them out
// byte-wise over valid/ready. Define CAPTURE_HEADER_EN to prefix two header bytes.
module sample_capture
    import capture_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 14,
    parameter int DEPTH_L1 = capture_pkg::DEPTH_L1,
    parameter int DEPTH_L2 = capture_pkg::DEPTH_L2,
    parameter int DEPTH_L3 = capture_pkg::DEPTH_L3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              adc_en,
    input  logic [1:0]        depth,
    input  logic              adc_clk,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              arm,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sample_cnt
);

    cap_state_t        state;
    logic              adc_clk_d;
    logic              rise;
    logic              we;
    logic              xfer;
    logic              hdr_phase;
    logic              last_byte;
    logic              rd_ok;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] cnt_next;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] hdr_byte;

    function automatic logic [ADDR_W-1:0] target_for(input logic [1:0] code);
        case (code)
            2'd1:    return ADDR_W'(DEPTH_L1);
            2'd2:    return ADDR_W'(DEPTH_L2);
            default: return ADDR_W'(DEPTH_L3);
        endcase
    endfunction

    assign rise      = adc_clk & ~adc_clk_d;
    assign we        = (state == CAPTURE) && rise && adc_en;
    assign xfer      = tx_valid & tx_ready;
    assign cnt_next  = sample_cnt + 1'b1;
    assign last_byte = (rd_ptr == target - 1'b1);

`ifdef CAPTURE_HEADER_EN
    logic [1:0] hdr_idx;
    logic [1:0] depth_lat;

    assign hdr_phase = (hdr_idx != 2'd2);
    assign hdr_byte  = (hdr_idx == 2'd0) ? DATA_W'(HDR_SYNC)
                                         : {{(DATA_W-2){1'b0}}, depth_lat};
`else
    assign hdr_phase = 1'b0;
    assign hdr_byte  = '0;
`endif

    // Look one address ahead on a sample transfer so the next byte is ready a cycle later.
    assign rd_addr = (state == DUMP && xfer && !hdr_phase) ? rd_ptr + 1'b1 : rd_ptr;

    sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH_L3)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (sample_cnt),
        .wdata (adc_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Acquisition FSM: arm latches the target depth, capture fills the RAM,
    // dump drains it through the TX handshake with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            adc_clk_d  <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
            target     <= '0;
            rd_ptr     <= '0;
            rd_ok      <= 1'b0;
`ifdef CAPTURE_HEADER_EN
            hdr_idx    <= 2'd0;
            depth_lat  <= 2'd0;
`endif
        end else begin
            adc_clk_d <= adc_clk;
            case (state)
                IDLE: begin
                    if (arm && depth != 2'd0) begin
                        target     <= target_for(depth);
                        sample_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= WAIT_TRIG;
`ifdef CAPTURE_HEADER_EN
                        depth_lat  <= depth;
`endif
                    end
                end
                WAIT_TRIG: begin
                    if (adc_en) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (we) begin
                        sample_cnt <= cnt_next;
                        if (cnt_next == target) begin
                            state  <= DUMP;
                            rd_ptr <= '0;
                            rd_ok  <= 1'b0;
`ifdef CAPTURE_HEADER_EN
                            hdr_idx <= 2'd0;
`endif
                        end
                    end
                end
                DUMP: begin
                    rd_ok <= 1'b1;
                    if (tx_valid) begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
`ifdef CAPTURE_HEADER_EN
                            if (hdr_phase) begin
                                hdr_idx <= hdr_idx + 1'b1;
                            end else
`endif
                            if (last_byte) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                rd_ptr <= rd_ptr + 1'b1;
                            end
                        end
                    end else if (hdr_phase) begin
                        tx_valid <= 1'b1;
                        tx_data  <= hdr_byte;
                    end else if (rd_ok) begin
                        tx_valid <= 1'b1;
                        tx_data  <= rd_data;
                    end
                end
                DONE: begin
                    if (arm) begin
                        done <= 1'b0;
                        if (depth != 2'd0) begin
                            target     <= target_for(depth);
                            sample_cnt <= '0;
                            busy       <= 1'b1;
                            state      <= WAIT_TRIG;
`ifdef CAPTURE_HEADER_EN
                            depth_lat  <= depth;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_capture.sv
// Scoreboard bench for sample_capture: stimulus pushes expected bytes, a
// negedge monitor pops and compares every handshake and checks stall stability.
module tb_sample_capture;

    logic        clk;
    logic        reset_n;
    logic        adc_en;
    logic [1:0]  depth;
    logic        adc_clk;
    logic [7:0]  adc_data;
    logic        arm;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic [13:0] sample_cnt;

    int         numTests = 0;
    int         numFailed = 0;
    logic [7:0] expQ[$];
    int         byteCount = 0;
    int         pushed = 0;
    int         target = 0;
    bit         capturing = 0;
    bit         readyRandom = 0;
    bit         prevStall = 0;
    logic [7:0] prevData = '0;

    sample_capture dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .adc_en     (adc_en),
        .depth      (depth),
        .adc_clk    (adc_clk),
        .adc_data   (adc_data),
        .arm        (arm),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numTests++;
        if (actual !== expected) begin
            numFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int modelTarget(input logic [1:0] code);
        case (code)
            2'd1:    return 1024;
            2'd2:    return 5120;
            2'd3:    return 10240;
            default: return 0;
        endcase
    endfunction

    function automatic int headerLen();
`ifdef CAPTURE_HEADER_EN
        return 2;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) begin
        #1;
        tx_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: every accepted byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (prevStall) begin
                checkOutput("hold_valid", {31'b0, tx_valid}, 32'd1);
                checkOutput("hold_data", {24'b0, tx_data}, {24'b0, prevData});
            end
            if (tx_valid && tx_ready) begin
                byteCount++;
                if (expQ.size() == 0) begin
                    numTests++;
                    numFailed++;
                    $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
                end else begin
                    checkOutput("tx_byte", {24'b0, tx_data}, {24'b0, expQ.pop_front()});
                end
            end
            prevStall = tx_valid && !tx_ready;
            prevData  = tx_data;
        end else begin
            prevStall = 1'b0;
        end
    end

    // One adc_clk rise carrying en/data; the model records it if it should be captured.
    task automatic applyStimulus(input logic en, input logic [7:0] data);
        @(posedge clk);
        #1;
        adc_clk  = 1'b1;
        adc_en   = en;
        adc_data = data;
        if (capturing && en && pushed < target) begin
            expQ.push_back(data);
            pushed++;
        end
        @(posedge clk);
        #1;
        adc_clk = 1'b0;
    endtask

    task automatic pulseArm(input logic [1:0] code);
        @(posedge clk);
        #1;
        depth = code;
        arm   = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
    endtask

    task automatic armCapture(input logic [1:0] code);
        target    = modelTarget(code);
        pushed    = 0;
        byteCount = 0;
        capturing = 1'b1;
`ifdef CAPTURE_HEADER_EN
        expQ.push_back(8'hA5);
        expQ.push_back({6'b0, code});
`endif
        adc_en = 1'b1;
        pulseArm(code);
        @(negedge clk);
        checkOutput("arm_cnt_clear", {18'b0, sample_cnt}, 32'd0);
        checkOutput("arm_busy", {31'b0, busy}, 32'd1);
    endtask

    task automatic waitDone();
        int cycles = 0;
        while (!(done && expQ.size() == 0) && cycles < 60000) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("done", {31'b0, done}, 32'd1);
        checkOutput("busy_in_done", {31'b0, busy}, 32'd0);
        checkOutput("valid_in_done", {31'b0, tx_valid}, 32'd0);
        checkOutput("final_cnt", {18'b0, sample_cnt}, target);
        checkOutput("byte_count", byteCount, target + headerLen());
        checkOutput("queue_drained", expQ.size(), 32'd0);
        capturing = 1'b0;
    endtask

    // mode 0: ramp data; 1: random data with a depth change; 2: random with an adc_en gap.
    task automatic runAcquisition(input logic [1:0] code, input int mode);
        bit gapDone = 0;
        armCapture(code);
        if (mode == 1) depth = 2'($urandom_range(0, 3));
        while (pushed < target) begin
            if (mode == 2 && !gapDone && pushed == 3000) begin
                for (int i = 0; i < 100; i++) begin
                    applyStimulus(1'b0, 8'($urandom));
                end
                @(posedge clk);
                #1;
                arm = 1'b1;
                @(posedge clk);
                #1;
                arm = 1'b0;
                gapDone = 1;
            end else if (mode == 0) begin
                applyStimulus(1'b1, pushed[7:0]);
            end else begin
                applyStimulus(1'b1, 8'($urandom));
            end
        end
        adc_en = 1'b0;
        waitDone();
    endtask

    initial begin
        reset_n  = 1'b0;
        adc_en   = 1'b0;
        depth    = 2'd0;
        adc_clk  = 1'b0;
        adc_data = '0;
        arm      = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", {31'b0, tx_valid}, 32'd0);
        checkOutput("rst_data", {24'b0, tx_data}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_cnt", {18'b0, sample_cnt}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] depth 1 ramp, tx_ready always high");
        runAcquisition(2'd1, 0);

        $display("[TB] depth 3 with 100-rise adc_en gap and ignored arm");
        runAcquisition(2'd3, 2);

        $display("[TB] depth 2 with random tx_ready and depth change");
        readyRandom = 1'b1;
        runAcquisition(2'd2, 1);
        readyRandom = 1'b0;

        $display("[TB] depth 0 arm ignored");
        pulseArm(2'd0);
        pulseArm(2'd0);
        repeat (20) applyStimulus(1'b1, 8'($urandom));
        @(negedge clk);
        checkOutput("d0_busy", {31'b0, busy}, 32'd0);
        checkOutput("d0_done", {31'b0, done}, 32'd0);
        checkOutput("d0_valid", {31'b0, tx_valid}, 32'd0);
        runAcquisition(2'd1, 1);

        $display("[TB] reset mid-capture");
        armCapture(2'd1);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'($urandom));
        @(negedge clk);
        checkOutput("cnt_before_reset", {18'b0, sample_cnt}, 32'd300);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
        checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("mid_rst_done", {31'b0, done}, 32'd0);
        checkOutput("mid_rst_cnt", {18'b0, sample_cnt}, 32'd0);
        expQ.delete();
        capturing = 1'b0;
        adc_en    = 1'b0;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        runAcquisition(2'd1, 0);

        $display("[TB] %0d tests run, %0d failed", numTests, numFailed);
        $finish;
    end

endmodule
